// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: instruction decode, FETCH/DECODE/EXECUTE/WB
// sequencing FSM, NZCV flag register and condition evaluation.
module multicycle_controller #(
  parameter int         ALUCTRL_W = 3,
  parameter logic [3:0] FLAG_RST  = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  flags_reg;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic [3:0]  rd;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign cmd   = funct[4:1];
  assign rd    = Instr[3:0];

  // Data-processing decode; dp_legal gates entry into the EXECUTE states.
  logic [2:0]  alu_dec;
  logic        dp_legal;
  logic        is_cmp;
  logic        is_arith;
  logic [1:0]  flag_w;

  always_comb begin
    alu_dec  = 3'b000;
    dp_legal = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = 3'b000; is_arith = 1'b1; end
      4'b0010: begin alu_dec = 3'b001; is_arith = 1'b1; end
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b1010: begin alu_dec = 3'b001; is_arith = 1'b1; is_cmp = 1'b1; end
      4'b0001: begin
        if (ALUCTRL_W >= 3) alu_dec = 3'b100;
        else                dp_legal = 1'b0;
      end
      default: dp_legal = 1'b0;
    endcase
    flag_w = (funct[0] | is_cmp) ? {1'b1, is_arith} : 2'b00;
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = ~flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = ~flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = ~flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = ~flag_v;
      4'h8: cond_ex = flag_c & ~flag_z;
      4'h9: cond_ex = ~flag_c | flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
      4'hD: cond_ex = flag_z | (flag_n != flag_v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
      flags_reg <= FLAG_RST;
    end else begin
      state_reg <= state_next;
      // Flags are captured from the ALU on the edge that ends the execute cycle.
      if (state_reg == EXECUTER || state_reg == EXECUTEI) begin
        if (flag_w[1] & cond_ex) flags_reg[3:2] <= ALUFlags[3:2];
        if (flag_w[0] & cond_ex) flags_reg[1:0] <= ALUFlags[1:0];
      end
    end
  end

  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic [2:0] alu_ctrl;

  always_comb begin
    state_next    = FETCH;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_ctrl      = 3'b000;
    case (state_reg)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        state_next   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (op == 2'b01)                  state_next = MEMADR;
        else if (op == 2'b10)             state_next = BRANCH;
        else if (op == 2'b00 && dp_legal) state_next = funct[5] ? EXECUTEI : EXECUTER;
        else                              state_next = FETCH;
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        if (rd == 4'hF) pc_write_raw  = cond_ex;
        else            reg_write_raw = cond_ex;
      end
      MEMWR: begin
        AdrSrc        = 1'b1;
        mem_write_raw = cond_ex;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_reg == EXECUTEI) ? 2'b01 : 2'b00;
        alu_ctrl   = alu_dec;
        state_next = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        if (rd == 4'hF) pc_write_raw  = cond_ex;
        else            reg_write_raw = cond_ex;
      end
      BRANCH: begin
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        pc_write_raw = cond_ex;
      end
      default: state_next = FETCH;
    endcase
  end

  // Write enables are masked by reset directly so an in-flight write dies at once.
  assign PCWrite    = pc_write_raw  & ~reset;
  assign MemWrite   = mem_write_raw & ~reset;
  assign IRWrite    = ir_write_raw  & ~reset;
  assign RegWrite   = reg_write_raw & ~reset;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign ALUControl = alu_ctrl[ALUCTRL_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{Instr[7:4], alu_ctrl};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction table, reset corner cases,
// and random instruction streams checked against a per-instruction cycle model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2, RegSrc2;
  logic [1:0] ALUControl2;

  multicycle_controller #(.ALUCTRL_W(3), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUControl(ALUControl)
  );

  multicycle_controller #(.ALUCTRL_W(2), .FLAG_RST(4'b0000)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
    .RegSrc(RegSrc2), .RegWrite(RegWrite2), .ALUControl(ALUControl2)
  );

  always #5 clk = ~clk;

  // [17]PCWrite [16]AdrSrc [15]MemWrite [14]IRWrite [13:12]ResultSrc [11:10]ALUSrcA
  // [9:8]ALUSrcB [7:6]ImmSrc [5:4]RegSrc [3]RegWrite [2:0]ALUControl
  logic [17:0] obs1, obs2;
  assign obs1 = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, RegSrc, RegWrite, ALUControl};
  assign obs2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, ResultSrc2, ALUSrcA2, ALUSrcB2,
                 ImmSrc2, RegSrc2, RegWrite2, 1'b0, ALUControl2};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [63:0] tag;
    logic [19:0] ins;
    logic [3:0]  af;
    logic [3:0]  cycles;
    logic [2:0]  alu;
    logic [7:0]  rw_m;
    logic [7:0]  pw_m;
    logic [7:0]  mw_m;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [63:0] tag, input logic [19:0] ins,
                              input logic [3:0] af, input logic [3:0] cyc,
                              input logic [2:0] alu, input logic [7:0] rw,
                              input logic [7:0] pw, input logic [7:0] mw);
    vec_t v;
    v.tag = tag; v.ins = ins; v.af = af; v.cycles = cyc; v.alu = alu;
    v.rw_m = rw; v.pw_m = pw; v.mw_m = mw;
    return v;
  endfunction

  function automatic logic [17:0] get_obs(input bit sel);
    return sel ? obs2 : obs1;
  endfunction

  // Runs one table entry starting in its FETCH cycle; ends in the following FETCH.
  task automatic run_dir(input int idx, input bit sel);
    vec_t        v;
    logic [17:0] o;
    logic [7:0]  rwm, pwm, mwm;
    logic [2:0]  alu_seen;
    int          ncyc;
    bit          done;
    v = tbl[idx];
    Instr = v.ins;
    ALUFlags = v.af;
    rwm = '0; pwm = '0; mwm = '0; alu_seen = '0; ncyc = 0; done = 0;
    #1;
    for (int c = 0; c < 8 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      o = get_obs(sel);
      if (c > 0 && o[14]) begin
        done = 1;
        ncyc = c;
      end else begin
        rwm[c] = o[3];
        pwm[c] = o[17];
        mwm[c] = o[15];
        if (c == 2) alu_seen = o[2:0];
      end
    end
    $display("tbl[%0d] %s ins=%h cycles=%0d alu=%b rw=%b pw=%b mw=%b",
             idx, v.tag, v.ins, ncyc, alu_seen, rwm, pwm, mwm);
    check($sformatf("%s.cycles", v.tag), 32'(ncyc), 32'(v.cycles));
    check($sformatf("%s.alu", v.tag), 32'(alu_seen), 32'(v.alu));
    check($sformatf("%s.regwrite", v.tag), 32'(rwm), 32'(v.rw_m));
    check($sformatf("%s.pcwrite", v.tag), 32'(pwm), 32'(v.pw_m));
    check($sformatf("%s.memwrite", v.tag), 32'(mwm), 32'(v.mw_m));
  endtask

  // ---------------- reference model ----------------
  localparam int K_NOP = 0, K_BR = 1, K_LDR = 2, K_STR = 3, K_DP = 4, K_CMP = 5;

  function automatic int kind_of(input logic [19:0] ins);
    logic [1:0] op;
    logic [3:0] cmd;
    op  = ins[15:14];
    cmd = ins[12:9];
    if (op == 2'b10) return K_BR;
    if (op == 2'b01) return ins[8] ? K_LDR : K_STR;
    if (op == 2'b00) begin
      if (cmd == 4'b1010) return K_CMP;
      if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
          cmd == 4'b1100 || cmd == 4'b0001) return K_DP;
    end
    return K_NOP;
  endfunction

  function automatic int n_cycles(input int k);
    int lat [6] = '{2, 3, 5, 4, 4, 3};
    return lat[k];
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 3'd0;
      4'b0010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b1010: return 3'd1;
      4'b0001: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for cycle c of an instruction (c=0 is its fetch).
  function automatic logic [17:0] model_vec(input logic [19:0] ins, input int c, input logic cx);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, op;
    logic [2:0] alu;
    int         k;
    bit         wb;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 0; sa = 0; sb = 0; alu = 0; wb = 0;
    op = ins[15:14];
    k = kind_of(ins);
    if (c == 0) begin
      pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10;
    end else if (c == 1) begin
      sa = 2'b01; sb = 2'b10; res = 2'b10;
    end else if (k == K_BR) begin
      sb = 2'b01; res = 2'b10; pcw = cx;
    end else if (k == K_LDR || k == K_STR) begin
      if (c == 2) sb = 2'b01;
      else if (c == 3) begin
        adr = 1;
        if (k == K_STR) mw = cx;
      end else begin
        res = 2'b01; wb = 1;
      end
    end else begin
      if (c == 2) begin
        sb = ins[13] ? 2'b01 : 2'b00;
        alu = alu_code(ins[12:9]);
      end else begin
        res = 2'b00; wb = 1;
      end
    end
    if (wb) begin
      if (ins[3:0] == 4'hF) pcw = cx;
      else                  rw = cx;
    end
    return {pcw, adr, mw, irw, res, sa, sb, op, op == 2'b01, op == 2'b10, rw, alu};
  endfunction

  function automatic logic [19:0] rand_instr();
    logic [3:0] cond, rn, rd, legal [6];
    logic [1:0] op;
    logic [5:0] funct;
    int         r;
    legal = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0001};
    cond  = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
    r     = $urandom_range(0, 9);
    op    = (r < 4 || r == 9) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
    funct = 6'($urandom_range(0, 63));
    if (op == 2'b00 && $urandom_range(0, 4) != 0) funct[4:1] = legal[$urandom_range(0, 5)];
    rn = 4'($urandom_range(0, 15));
    rd = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    return {cond, op, funct, rn, rd};
  endfunction

  logic [19:0] rins;
  logic [3:0]  mflags;
  logic [17:0] expv;
  logic        cx;
  int          k, n;

  initial begin
    tbl[0]  = mk("ADD",    20'hE0812, 4'hF, 4'd4, 3'b000, 8'h08, 8'h01, 8'h00);
    tbl[1]  = mk("BEQ0",   20'h0A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[2]  = mk("SUBS",   20'hE2511, 4'h4, 4'd4, 3'b001, 8'h08, 8'h01, 8'h00);
    tbl[3]  = mk("BEQ",    20'h0A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h05, 8'h00);
    tbl[4]  = mk("BNE",    20'h1A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[5]  = mk("LDR",    20'hE5912, 4'h0, 4'd5, 3'b000, 8'h10, 8'h01, 8'h00);
    tbl[6]  = mk("STR",    20'hE5812, 4'h0, 4'd4, 3'b000, 8'h00, 8'h01, 8'h08);
    tbl[7]  = mk("CMP",    20'hE1510, 4'h8, 4'd3, 3'b001, 8'h00, 8'h01, 8'h00);
    tbl[8]  = mk("BMI",    20'h4A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h05, 8'h00);
    tbl[9]  = mk("BEQ1",   20'h0A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[10] = mk("EOR",    20'hE0212, 4'hF, 4'd4, 3'b100, 8'h08, 8'h01, 8'h00);
    tbl[11] = mk("ADDPC",  20'hE081F, 4'h0, 4'd4, 3'b000, 8'h00, 8'h09, 8'h00);
    tbl[12] = mk("ADDEQ",  20'h00812, 4'h0, 4'd4, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[13] = mk("OP11",   20'hEC000, 4'h0, 4'd2, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[14] = mk("ILLCMD", 20'hE0C12, 4'h0, 4'd2, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[15] = mk("ANDS",   20'hE0112, 4'h6, 4'd4, 3'b010, 8'h08, 8'h01, 8'h00);
    tbl[16] = mk("BEQ2",   20'h0A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h05, 8'h00);
    tbl[17] = mk("BCS",    20'h2A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[18] = mk("RBEQ",   20'h0A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h01, 8'h00);
    tbl[19] = mk("RBNE",   20'h1A000, 4'h0, 4'd3, 3'b000, 8'h00, 8'h05, 8'h00);

    reset = 1'b1;
    Instr = 20'hE0812;
    ALUFlags = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.write_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'h0);
    check("reset.fetch_srcb", 32'(ALUSrcB), 32'h2);
    $display("reset held: we=%b srcb=%b", {PCWrite, IRWrite, MemWrite, RegWrite}, ALUSrcB);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run_dir(i, 1'b0);

    // Async reset landing in MEMWR while MemWrite is asserted.
    Instr = 20'hE5812;
    ALUFlags = 4'h0;
    #1;
    repeat (3) @(negedge clk);
    #1;
    check("memwr.before_reset", 32'(MemWrite), 32'h1);
    reset = 1'b1;
    #1;
    $display("reset in MEMWR: memwrite=%b we=%b srcb=%b", MemWrite,
             {PCWrite, IRWrite, RegWrite}, ALUSrcB);
    check("memwr.after_reset", 32'(MemWrite), 32'h0);
    check("memwr.reset_we", 32'({PCWrite, IRWrite, RegWrite}), 32'h0);
    check("memwr.reset_state_fetch", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'h1A);
    @(negedge clk);
    reset = 1'b0;
    run_dir(18, 1'b0);
    run_dir(19, 1'b0);

    // Two-bit ALUControl variant treats EOR as an illegal op.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tbl[0] = mk("EOR2",   20'hE0212, 4'hF, 4'd2, 3'b000, 8'h00, 8'h01, 8'h00);
    run_dir(0, 1'b1);

    // Random instruction stream against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mflags = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      rins = rand_instr();
      Instr = rins;
      k = kind_of(rins);
      n = n_cycles(k);
      for (int c = 0; c < n; c++) begin
        ALUFlags = 4'($urandom_range(0, 15));
        #1;
        cx = cond_ok(rins[19:16], mflags);
        expv = model_vec(rins, c, cx);
        check($sformatf("rand%0d.c%0d", i, c), 32'(obs1), 32'(expv));
        if ((k == K_DP || k == K_CMP) && c == 2 && cx &&
            (rins[8] || k == K_CMP)) begin
          if (k == K_CMP || rins[12:9] == 4'b0100 || rins[12:9] == 4'b0010)
            mflags = ALUFlags;
          else
            mflags[3:2] = ALUFlags[3:2];
        end
        @(negedge clk);
      end
      $display("rand%0d ins=%h kind=%0d cycles=%0d flags=%b", i, rins, k, n, mflags);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
